// File: rtl/best_gain_sequencer.sv
// best_gain_sequencer: issues one evaluation request per candidate variable
// and keeps the highest-gain candidate (lowest index wins on a tie).
// When every candidate has come back, it publishes that candidate with a
// one-cycle out_done pulse.
module best_gain_sequencer #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE       = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
    parameter int TOTAL_NUMBER_OF_VARIABLES =
        2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX + 2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    parameter int VARIABLE_COUNTER_WIDTH = 3,
    localparam int G      = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1,
    localparam int W      = VARIABLE_COUNTER_WIDTH,
    localparam int INT_W  = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE * (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX),
    localparam int BOOL_W = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE * (2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_start,
    input  logic              in_abort,
    output logic              out_busy,
    output logic              out_request_valid,
    output logic [W-1:0]      out_request_index,
    input  logic              in_request_ready,
    input  logic              in_candidate_valid,
    input  logic [G-1:0]      in_candidate_gain,
    input  logic [INT_W-1:0]  in_candidate_integer_assignment,
    input  logic [BOOL_W-1:0] in_candidate_boolean_assignment,
    output logic              out_done,
    output logic [G-1:0]      out_best_gain,
    output logic [W-1:0]      out_best_index,
    output logic [INT_W-1:0]  out_best_integer_assignment,
    output logic [BOOL_W-1:0] out_best_boolean_assignment
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [W-1:0] N_W    = W'(TOTAL_NUMBER_OF_VARIABLES);
    localparam logic [W-1:0] LAST_W = W'(TOTAL_NUMBER_OF_VARIABLES - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       issue_q, issue_d;
    logic [W-1:0]       recv_q, recv_d;
    logic [G-1:0]       run_gain_q, run_gain_d;
    logic [W-1:0]       run_idx_q, run_idx_d;
    logic [INT_W-1:0]   run_int_q, run_int_d;
    logic [BOOL_W-1:0]  run_bool_q, run_bool_d;
    logic [G-1:0]       best_gain_q, best_gain_d;
    logic [W-1:0]       best_idx_q, best_idx_d;
    logic [INT_W-1:0]   best_int_q, best_int_d;
    logic [BOOL_W-1:0]  best_bool_q, best_bool_d;

    logic               req_valid_s;
    logic               accept_s;
    logic               take_s;
    logic               last_s;
    logic [G-1:0]       sel_gain_s;
    logic [W-1:0]       sel_idx_s;
    logic [INT_W-1:0]   sel_int_s;
    logic [BOOL_W-1:0]  sel_bool_s;

    // Handshake qualifiers and the running best after considering this cycle's candidate.
    // Candidates return in request order, so the receive counter is the candidate's index.
    always_comb begin
        req_valid_s = (state_q == ST_RUN) && (issue_q < N_W);
        accept_s    = (state_q == ST_RUN) && in_candidate_valid;
        take_s      = accept_s && ((recv_q == {W{1'b0}}) || (in_candidate_gain > run_gain_q));
        last_s      = accept_s && (recv_q == LAST_W);
        if (take_s) begin
            sel_gain_s = in_candidate_gain;
            sel_idx_s  = recv_q;
            sel_int_s  = in_candidate_integer_assignment;
            sel_bool_s = in_candidate_boolean_assignment;
        end else begin
            sel_gain_s = run_gain_q;
            sel_idx_s  = run_idx_q;
            sel_int_s  = run_int_q;
            sel_bool_s = run_bool_q;
        end
    end

    // Next-state logic: search sequencing, counters and result capture on DONE entry.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        recv_d      = recv_q;
        run_gain_d  = run_gain_q;
        run_idx_d   = run_idx_q;
        run_int_d   = run_int_q;
        run_bool_d  = run_bool_q;
        best_gain_d = best_gain_q;
        best_idx_d  = best_idx_q;
        best_int_d  = best_int_q;
        best_bool_d = best_bool_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start && !in_abort) begin
                    state_d = ST_RUN;
                    issue_d = {W{1'b0}};
                    recv_d  = {W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over everything, including the final candidate.
                if (in_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (req_valid_s && in_request_ready) begin
                        issue_d = issue_q + 1'b1;
                    end else begin
                        issue_d = issue_q;
                    end
                    if (accept_s) begin
                        recv_d     = recv_q + 1'b1;
                        run_gain_d = sel_gain_s;
                        run_idx_d  = sel_idx_s;
                        run_int_d  = sel_int_s;
                        run_bool_d = sel_bool_s;
                    end else begin
                        recv_d = recv_q;
                    end
                    if (last_s) begin
                        state_d     = ST_DONE;
                        best_gain_d = sel_gain_s;
                        best_idx_d  = sel_idx_s;
                        best_int_d  = sel_int_s;
                        best_bool_d = sel_bool_s;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= ST_IDLE;
            issue_q     <= {W{1'b0}};
            recv_q      <= {W{1'b0}};
            run_gain_q  <= {G{1'b0}};
            run_idx_q   <= {W{1'b0}};
            run_int_q   <= {INT_W{1'b0}};
            run_bool_q  <= {BOOL_W{1'b0}};
            best_gain_q <= {G{1'b0}};
            best_idx_q  <= {W{1'b0}};
            best_int_q  <= {INT_W{1'b0}};
            best_bool_q <= {BOOL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            recv_q      <= recv_d;
            run_gain_q  <= run_gain_d;
            run_idx_q   <= run_idx_d;
            run_int_q   <= run_int_d;
            run_bool_q  <= run_bool_d;
            best_gain_q <= best_gain_d;
            best_idx_q  <= best_idx_d;
            best_int_q  <= best_int_d;
            best_bool_q <= best_bool_d;
        end
    end

    assign out_busy                    = (state_q == ST_RUN);
    assign out_done                    = (state_q == ST_DONE);
    assign out_request_valid           = req_valid_s;
    assign out_request_index           = req_valid_s ? issue_q : {W{1'b0}};
    assign out_best_gain               = best_gain_q;
    assign out_best_index              = best_idx_q;
    assign out_best_integer_assignment = best_int_q;
    assign out_best_boolean_assignment = best_bool_q;

endmodule

// File: tb/tb_best_gain_sequencer.sv
// Self-checking bench for best_gain_sequencer (default parameters: N=4, G=3, W=3).
// An evaluator model answers each accepted request one cycle later. A reference
// model picks the best candidate as the first index with the maximum gain.
module tb_best_gain_sequencer;

    localparam int N      = 4;
    localparam int G      = 3;
    localparam int W      = 3;
    localparam int INT_W  = 8;
    localparam int BOOL_W = 2;

    logic              in_clk = 1'b0;
    logic              in_reset;
    logic              in_start;
    logic              in_abort;
    logic              out_busy;
    logic              out_request_valid;
    logic [W-1:0]      out_request_index;
    logic              in_request_ready;
    logic              in_candidate_valid;
    logic [G-1:0]      in_candidate_gain;
    logic [INT_W-1:0]  in_candidate_integer_assignment;
    logic [BOOL_W-1:0] in_candidate_boolean_assignment;
    logic              out_done;
    logic [G-1:0]      out_best_gain;
    logic [W-1:0]      out_best_index;
    logic [INT_W-1:0]  out_best_integer_assignment;
    logic [BOOL_W-1:0] out_best_boolean_assignment;

    int checks = 0;
    int errors = 0;

    logic [G-1:0]      gains    [N];
    logic [INT_W-1:0]  int_asg  [N];
    logic [BOOL_W-1:0] bool_asg [N];

    logic [G-1:0]      exp_gain;
    logic [W-1:0]      exp_idx;
    logic [INT_W-1:0]  exp_int;
    logic [BOOL_W-1:0] exp_bool;

    best_gain_sequencer dut (
        .in_clk                          (in_clk),
        .in_reset                        (in_reset),
        .in_start                        (in_start),
        .in_abort                        (in_abort),
        .out_busy                        (out_busy),
        .out_request_valid               (out_request_valid),
        .out_request_index               (out_request_index),
        .in_request_ready                (in_request_ready),
        .in_candidate_valid              (in_candidate_valid),
        .in_candidate_gain               (in_candidate_gain),
        .in_candidate_integer_assignment (in_candidate_integer_assignment),
        .in_candidate_boolean_assignment (in_candidate_boolean_assignment),
        .out_done                        (out_done),
        .out_best_gain                   (out_best_gain),
        .out_best_index                  (out_best_index),
        .out_best_integer_assignment     (out_best_integer_assignment),
        .out_best_boolean_assignment     (out_best_boolean_assignment)
    );

    always #5 in_clk = ~in_clk;

    // Reference: the first index holding the maximum gain.
    function automatic int ref_best();
        int b = 0;
        for (int i = 1; i < N; i++) begin
            if (gains[i] > gains[b]) b = i;
        end
        return b;
    endfunction

    task automatic set_gains(input int g0, input int g1, input int g2, input int g3);
        gains[0] = G'(g0); gains[1] = G'(g1); gains[2] = G'(g2); gains[3] = G'(g3);
        for (int i = 0; i < N; i++) begin
            int_asg[i]  = INT_W'($urandom);
            bool_asg[i] = BOOL_W'($urandom);
        end
    endtask

    task automatic randomize_gains();
        set_gains($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    // One search with evaluator model; optional ready stall, random ready, abort, held start.
    task automatic run_search(input int stall_at, input bit rand_ready, input int abort_at,
                              input bit keep_start, output int done_cycle);
        int issued, received, pend_now, pend_next, stall_cnt, bi;
        bit exp_done, exp_v, rdy, last_presented;
        issued = 0; received = 0; pend_next = -1; stall_cnt = 3; last_presented = 0; done_cycle = -1;
        in_start = 1'b0; in_abort = 1'b0; in_candidate_valid = 1'b0; in_request_ready = 1'b0;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        if (!keep_start) in_start = 1'b0;
        for (int cyc = 1; cyc < 80; cyc++) begin
            exp_done = last_presented;
            checks++;
            if (out_done !== exp_done) begin
                errors++; $display("FAIL done_pulse cyc=%0d got=%b want=%b", cyc, out_done, exp_done);
            end
            checks++;
            if (out_busy !== !exp_done) begin
                errors++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, out_busy, !exp_done);
            end
            if (exp_done) begin
                done_cycle = cyc;
                bi = ref_best();
                exp_gain = gains[bi]; exp_idx = W'(bi); exp_int = int_asg[bi]; exp_bool = bool_asg[bi];
                in_candidate_valid = 1'b0; in_request_ready = 1'b0;
                checks++;
                if (out_best_gain !== exp_gain) begin
                    errors++; $display("FAIL best_gain got=%0d want=%0d", out_best_gain, exp_gain);
                end
                checks++;
                if (out_best_index !== exp_idx) begin
                    errors++; $display("FAIL best_index got=%0d want=%0d", out_best_index, exp_idx);
                end
                checks++;
                if (out_best_integer_assignment !== exp_int) begin
                    errors++; $display("FAIL best_int got=%h want=%h", out_best_integer_assignment, exp_int);
                end
                checks++;
                if (out_best_boolean_assignment !== exp_bool) begin
                    errors++; $display("FAIL best_bool got=%h want=%h", out_best_boolean_assignment, exp_bool);
                end
                return;
            end
            pend_now = pend_next; pend_next = -1;
            if (pend_now >= 0) begin
                in_candidate_valid = 1'b1;
                in_candidate_gain = gains[pend_now];
                in_candidate_integer_assignment = int_asg[pend_now];
                in_candidate_boolean_assignment = bool_asg[pend_now];
            end else begin
                in_candidate_valid = 1'b0;
                in_candidate_gain = G'($urandom);
                in_candidate_integer_assignment = INT_W'($urandom);
                in_candidate_boolean_assignment = BOOL_W'($urandom);
            end
            if (abort_at >= 0 && received == abort_at) begin
                in_abort = 1'b1; in_request_ready = 1'b1;
                @(posedge in_clk); #1;
                in_abort = 1'b0; in_candidate_valid = 1'b0; in_request_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (out_busy !== 1'b0 || out_done !== 1'b0) begin
                        errors++; $display("FAIL abort_idle k=%0d busy=%b done=%b want 0 0", k, out_busy, out_done);
                    end
                    checks++;
                    if (out_best_gain !== exp_gain || out_best_index !== exp_idx ||
                        out_best_integer_assignment !== exp_int || out_best_boolean_assignment !== exp_bool) begin
                        errors++; $display("FAIL abort_hold got=%0d/%0d/%h/%h want=%0d/%0d/%h/%h",
                            out_best_gain, out_best_index, out_best_integer_assignment, out_best_boolean_assignment,
                            exp_gain, exp_idx, exp_int, exp_bool);
                    end
                    @(posedge in_clk); #1;
                end
                return;
            end
            if (pend_now >= 0) begin
                received++;
                last_presented = (received == N);
            end
            if (rand_ready) rdy = 1'($urandom_range(0, 1));
            else if (stall_at >= 0 && issued == stall_at && stall_cnt > 0) begin
                rdy = 1'b0; stall_cnt--;
            end else rdy = 1'b1;
            in_request_ready = rdy;
            exp_v = (issued < N);
            checks++;
            if (out_request_valid !== exp_v) begin
                errors++; $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, out_request_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_request_index !== W'(issued)) begin
                    errors++; $display("FAIL req_index cyc=%0d got=%0d want=%0d", cyc, out_request_index, issued);
                end
            end
            if (exp_v && rdy) begin
                pend_next = issued; issued++;
            end
            @(posedge in_clk); #1;
        end
        checks++; errors++;
        $display("FAIL search_timeout no out_done within cycle budget");
    endtask

    task automatic test_reset();
        in_reset = 1'b0; in_start = 1'b1; in_abort = 1'b0; in_request_ready = 1'b1;
        in_candidate_valid = 1'b1; in_candidate_gain = 3'd7;
        in_candidate_integer_assignment = 8'hFF; in_candidate_boolean_assignment = 2'b11;
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({out_busy, out_request_valid, out_request_index, out_done, out_best_gain, out_best_index,
             out_best_integer_assignment, out_best_boolean_assignment} !== 22'd0) begin
            errors++; $display("FAIL reset_outputs busy=%b rv=%b ri=%0d done=%b bg=%0d bi=%0d",
                out_busy, out_request_valid, out_request_index, out_done, out_best_gain, out_best_index);
        end
        @(negedge in_clk);
        in_reset = 1'b1; in_start = 1'b0; in_candidate_valid = 1'b0; in_request_ready = 1'b0;
        exp_gain = 3'd0; exp_idx = 3'd0; exp_int = 8'd0; exp_bool = 2'd0;
    endtask

    task automatic test_basic();
        int dc;
        set_gains(2, 5, 3, 1);
        run_search(-1, 1'b0, -1, 1'b0, dc);
        checks++;
        if (dc !== N + 2) begin
            errors++; $display("FAIL latency got=%0d want=%0d", dc, N + 2);
        end
        @(posedge in_clk); #1;
        checks++;
        if (out_done !== 1'b0 || out_busy !== 1'b0) begin
            errors++; $display("FAIL single_pulse done=%b busy=%b want 0 0", out_done, out_busy);
        end
    endtask

    task automatic test_ties();
        int dc;
        set_gains(4, 4, 7, 7);
        run_search(-1, 1'b0, -1, 1'b0, dc);
        set_gains(0, 0, 0, 0);
        run_search(-1, 1'b0, -1, 1'b0, dc);
        set_gains(6, 1, 6, 2);
        run_search(-1, 1'b0, -1, 1'b0, dc);
    endtask

    task automatic test_stall();
        int dc;
        randomize_gains();
        run_search(2, 1'b0, -1, 1'b0, dc);
    endtask

    task automatic test_abort();
        int dc;
        set_gains(3, 6, 1, 2);
        run_search(-1, 1'b0, -1, 1'b0, dc);
        set_gains(7, 7, 7, 7);
        run_search(-1, 1'b0, 2, 1'b0, dc);
        // Stray candidate while idle must not touch anything.
        in_candidate_valid = 1'b1; in_candidate_gain = 3'd7;
        in_candidate_integer_assignment = 8'hA5; in_candidate_boolean_assignment = 2'b10;
        @(posedge in_clk); #1;
        in_candidate_valid = 1'b0;
        checks++;
        if (out_busy !== 1'b0 || out_best_gain !== exp_gain || out_best_index !== exp_idx ||
            out_best_integer_assignment !== exp_int) begin
            errors++; $display("FAIL stray_idle busy=%b bg=%0d bi=%0d want 0 %0d %0d",
                out_busy, out_best_gain, out_best_index, exp_gain, exp_idx);
        end
        // Abort coinciding with the final candidate wins.
        set_gains(7, 7, 7, 7);
        run_search(-1, 1'b0, 3, 1'b0, dc);
        set_gains(1, 2, 3, 4);
        run_search(-1, 1'b0, -1, 1'b0, dc);
    endtask

    task automatic test_async_reset();
        int dc;
        in_start = 1'b0; in_request_ready = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b0;
        @(posedge in_clk); #1;
        #3 in_reset = 1'b0;
        #1;
        checks++;
        if ({out_busy, out_request_valid, out_request_index, out_done, out_best_gain, out_best_index,
             out_best_integer_assignment, out_best_boolean_assignment} !== 22'd0) begin
            errors++; $display("FAIL async_reset busy=%b rv=%b ri=%0d bg=%0d bi=%0d",
                out_busy, out_request_valid, out_request_index, out_best_gain, out_best_index);
        end
        #12 in_reset = 1'b1;
        exp_gain = 3'd0; exp_idx = 3'd0; exp_int = 8'd0; exp_bool = 2'd0;
        in_request_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge in_clk); #1;
            checks++;
            if (out_busy !== 1'b0 || out_request_valid !== 1'b0 || out_done !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle busy=%b rv=%b done=%b want 0 0 0",
                    out_busy, out_request_valid, out_done);
            end
        end
        randomize_gains();
        run_search(-1, 1'b0, -1, 1'b0, dc);
    endtask

    task automatic test_start_held();
        int dc;
        randomize_gains();
        run_search(-1, 1'b0, -1, 1'b1, dc);
        @(posedge in_clk); #1;
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++; $display("FAIL held_idle busy=%b done=%b want 0 0", out_busy, out_done);
        end
        @(posedge in_clk); #1;
        checks++;
        if (out_busy !== 1'b1 || out_request_valid !== 1'b1 || out_request_index !== 3'd0) begin
            errors++; $display("FAIL held_restart busy=%b rv=%b ri=%0d want 1 1 0",
                out_busy, out_request_valid, out_request_index);
        end
        in_start = 1'b0; in_abort = 1'b1;
        @(posedge in_clk); #1;
        in_abort = 1'b0;
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++; $display("FAIL held_abort busy=%b done=%b want 0 0", out_busy, out_done);
        end
    endtask

    task automatic test_random();
        int dc;
        for (int t = 0; t < 10; t++) begin
            randomize_gains();
            run_search(-1, 1'b1, -1, 1'b0, dc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_stall();
        test_abort();
        test_async_reset();
        test_start_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
